serial_code_lock: RTL and testbench
===================================

Name: serial_code_lock

Overview:
Parametrised serial combination lock, the next generation of the fixed 7-bit lock FSM.
- Compares a validated serial bit stream against a CODE_LEN-bit code held in a register, loaded from CODE at reset and reprogrammable while unlocked.
- Adds a configurable error hold time, failure counting and a timed lockout after MAX_FAILS consecutive wrong attempts.
- Sits between a debounced keypad/serial front end and the door/actuator control logic.

Parameters:
CODE_LEN, 7, number of code bits (>=1)
CODE, 7'b1011000, reset code; MSB is the first bit entered
ERR_CYCLES, 2, clock cycles ERROR is held after a wrong bit (>=1)
MAX_FAILS, 3, consecutive failed attempts that trigger lockout (>=1)
LOCKOUT_CYCLES, 16, clock cycles the lockout lasts (>=1)

Ports:
clk  in  1  system clock, rising edge
resetn  in  1  asynchronous active-low reset
in_valid  in  1  in_bit is sampled only in cycles where this is 1
in_bit  in  1  serial code bit
prog_en  in  1  load new_code into the code register (honoured only in UNLOCKED)
new_code  in  CODE_LEN  replacement code, MSB first
unlock  out  1  1 while in UNLOCKED
error  out  1  1 while in ERROR
lockout  out  1  1 while in LOCKOUT
fail_count  out  clog2(MAX_FAILS+1)  consecutive failed attempts since last success/lockout

Behaviour:
- Reset (resetn=0, asynchronous):
  - state=COLLECT, bit index idx=0, fail_count=0, timer=0, code_reg=CODE.
  - unlock, error and lockout are all 0.
- Outputs are Moore, decoded from the registered state only. At most one of unlock/error/lockout is 1 in any cycle.
- COLLECT:
  - Cycles with in_valid=0 change nothing.
  - With in_valid=1, compare in_bit against code_reg[CODE_LEN-1-idx].
  - Match, idx<CODE_LEN-1: idx++.
  - Match, idx=CODE_LEN-1: go to UNLOCKED, idx=0, fail_count=0.
  - Mismatch: go to ERROR, idx=0, timer=ERR_CYCLES-1, fail_count increments (saturates at MAX_FAILS).
  - Latency: unlock/error rise in the cycle following the clock edge that sampled the deciding bit.
- ERROR:
  - in_valid is ignored.
  - Each cycle, the timer decrements. At timer=0, leave ERROR. Result: error stays high for exactly ERR_CYCLES cycles.
  - Exit to LOCKOUT if fail_count=MAX_FAILS (timer=LOCKOUT_CYCLES-1); otherwise exit to COLLECT.
- LOCKOUT:
  - in_valid and prog_en are ignored.
  - lockout stays high for exactly LOCKOUT_CYCLES cycles.
  - On exit: go to COLLECT, fail_count=0, idx=0.
- UNLOCKED:
  - in_valid=1 with in_bit=0: stay in UNLOCKED.
  - in_valid=1 with in_bit=1: relock to COLLECT with idx=0.
  - prog_en=1: code_reg<=new_code on that edge. If a relock bit arrives in the same cycle, both actions occur.
  - prog_en in any other state has no effect.
- A wrong bit always aborts the attempt. There is no sliding-window re-match.
- Timer width: clog2(max(ERR_CYCLES, LOCKOUT_CYCLES)+1).
- Reset mid-attempt, mid-error or mid-lockout returns to the reset state immediately, including code_reg=CODE (a programmed code is lost).
- Illegal state encodings recover to COLLECT with idx=0 on the next edge.

Decomposition:
- Shared header lock_defs.vh holds:
  - state encodings ST_COLLECT, ST_UNLOCKED, ST_ERROR, ST_LOCKOUT (2 bits);
  - a clog2 constant function reused by sibling blocks.
- One sub-module, hold_timer, is natural:
  - load and value inputs, a done output;
  - a down-counter parametrised by width;
  - shared by the ERROR and LOCKOUT states.

Test Plan:
1. Reset, then valid bits 1,0,1,1,0,0,0 on consecutive cycles -> unlock=1 from the cycle after the 7th bit; fail_count=0; error never asserted.
2. Unlocked, then valid bits 0,0 then 1 -> unlock stays 1 through the zeros and drops the cycle after the 1; idx=0; a new full code unlocks again.
3. Bits 1,1 (wrong at idx 1) -> error=1 for exactly 2 cycles; fail_count=1; bits sent during ERROR are ignored; then back in COLLECT.
4. Three consecutive wrong attempts -> after the 3rd error window, lockout=1 for exactly 16 cycles with a correct code sent inside it ignored; afterwards fail_count=0 and a correct code unlocks.
5. In UNLOCKED, prog_en=1 with new_code=7'b0000001, then relock -> old code 1011000 gives error; 0,0,0,0,0,0,1 gives unlock; resetn pulse restores 1011000.
6. resetn asserted asynchronously mid-lockout and mid-attempt (idx=4) -> all outputs 0 immediately; state COLLECT; idx=0; fail_count=0.

Source files
------------

// File: rtl/serial_code_lock_pkg.sv
// Shared definitions for the serial code lock: state encodings and a
// constant clog2 used to size counters in sibling blocks.
package serial_code_lock_pkg;

  typedef enum logic [1:0] {
    ST_COLLECT  = 2'b00,
    ST_UNLOCKED = 2'b01,
    ST_ERROR    = 2'b10,
    ST_LOCKOUT  = 2'b11
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/serial_code_lock_hold_timer.sv
// Loadable down-counter; done is high while the count is zero. Shared by
// the error hold window and the lockout window.
module hold_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         done
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = value;
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/serial_code_lock.sv
// Parametrised serial combination lock with error hold, consecutive
// failure counting and timed lockout; code reprogrammable while unlocked.
//
// state       | meaning
// ------------+-----------------------------------------------------
// ST_COLLECT  | comparing valid bits against code_reg, MSB first
// ST_UNLOCKED | code accepted; 1 relocks, prog_en reloads code
// ST_ERROR    | wrong bit seen; held for ERR_CYCLES cycles
// ST_LOCKOUT  | MAX_FAILS consecutive failures; held LOCKOUT_CYCLES
module serial_code_lock
  import serial_code_lock_pkg::*;
#(
  parameter int                  CODE_LEN       = 7,
  parameter logic [CODE_LEN-1:0] CODE           = 7'b1011000,
  parameter int                  ERR_CYCLES     = 2,
  parameter int                  MAX_FAILS      = 3,
  parameter int                  LOCKOUT_CYCLES = 16
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic                              in_valid,
  input  logic                              in_bit,
  input  logic                              prog_en,
  input  logic [CODE_LEN-1:0]               new_code,
  output logic                              unlock,
  output logic                              error,
  output logic                              lockout,
  output logic [clog2(MAX_FAILS+1)-1:0]     fail_count
);

  localparam int FW = clog2(MAX_FAILS + 1);
  localparam int TW = clog2(max2(ERR_CYCLES, LOCKOUT_CYCLES) + 1);
  localparam int IW = (CODE_LEN > 1) ? clog2(CODE_LEN) : 1;

  localparam logic [TW-1:0] ERR_LOAD  = TW'(ERR_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [FW-1:0] FAIL_MAX  = FW'(MAX_FAILS);
  localparam logic [IW-1:0] IDX_LAST  = IW'(CODE_LEN - 1);

  state_e                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [FW-1:0]         fail_q, fail_d;
  logic [CODE_LEN-1:0]   code_q, code_d;
  logic [CODE_LEN-1:0]   code_rev;
  logic                  tmr_load;
  logic [TW-1:0]         tmr_val;
  logic                  tmr_done;

  // Bit-reverse so idx addresses the code in entry order (MSB first).
  always_comb begin
    code_rev = '0;
    for (int i = 0; i < CODE_LEN; i++)
      code_rev[i] = code_q[CODE_LEN-1-i];
  end

  hold_timer #(.W(TW)) u_hold_timer (
    .clk    (clk),
    .resetn (resetn),
    .load   (tmr_load),
    .value  (tmr_val),
    .done   (tmr_done)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    fail_d   = fail_q;
    code_d   = code_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      ST_COLLECT: begin
        if (in_valid) begin
          if (in_bit == code_rev[idx_q]) begin
            if (idx_q == IDX_LAST) begin
              state_d = ST_UNLOCKED;
              idx_d   = '0;
              fail_d  = '0;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            state_d  = ST_ERROR;
            idx_d    = '0;
            tmr_load = 1'b1;
            tmr_val  = ERR_LOAD;
            if (fail_q != FAIL_MAX) fail_d = fail_q + 1'b1;
          end
        end
      end
      ST_ERROR: begin
        if (tmr_done) begin
          if (fail_q == FAIL_MAX) begin
            state_d  = ST_LOCKOUT;
            tmr_load = 1'b1;
            tmr_val  = LOCK_LOAD;
          end else begin
            state_d = ST_COLLECT;
          end
        end
      end
      ST_LOCKOUT: begin
        if (tmr_done) begin
          state_d = ST_COLLECT;
          fail_d  = '0;
          idx_d   = '0;
        end
      end
      ST_UNLOCKED: begin
        if (prog_en) code_d = new_code;
        if (in_valid && in_bit) begin
          state_d = ST_COLLECT;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = ST_COLLECT;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_COLLECT;
      idx_q   <= '0;
      fail_q  <= '0;
      code_q  <= CODE;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      fail_q  <= fail_d;
      code_q  <= code_d;
    end
  end

  assign unlock     = (state_q == ST_UNLOCKED);
  assign error      = (state_q == ST_ERROR);
  assign lockout    = (state_q == ST_LOCKOUT);
  assign fail_count = fail_q;

endmodule

// File: tb/tb_serial_code_lock.sv
// Directed bench for serial_code_lock with default parameters; inputs are
// driven and outputs sampled on the falling clock edge.
module tb_serial_code_lock;

  logic       clk;
  logic       resetn;
  logic       in_valid;
  logic       in_bit;
  logic       prog_en;
  logic [6:0] new_code;
  logic       unlock;
  logic       error;
  logic       lockout;
  logic [1:0] fail_count;

  int checks;
  int errors;

  serial_code_lock dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_bit     (in_bit),
    .prog_en    (prog_en),
    .new_code   (new_code),
    .unlock     (unlock),
    .error      (error),
    .lockout    (lockout),
    .fail_count (fail_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    in_valid = 1'b1;
    in_bit   = b;
    @(negedge clk);
    in_valid = 1'b0;
    in_bit   = 1'b0;
  endtask

  task automatic send_code(input logic [6:0] c, input string tag);
    for (int i = 6; i >= 0; i--) begin
      send_bit(c[i]);
      chk({tag, "_err"}, int'(error), 0);
      chk({tag, "_unl"}, int'(unlock), (i == 0) ? 1 : 0);
    end
  endtask

  task automatic outs_idle(input string tag);
    chk({tag, "_unl"}, int'(unlock), 0);
    chk({tag, "_err"}, int'(error), 0);
    chk({tag, "_lck"}, int'(lockout), 0);
    chk({tag, "_fc"},  int'(fail_count), 0);
  endtask

  // One wrong first bit (0) against code 1011000, then ride out the 2-cycle window.
  task automatic wrong_attempt(input int exp_fc, input string tag);
    send_bit(1'b0);
    chk({tag, "_e1"}, int'(error), 1);
    chk({tag, "_fc"}, int'(fail_count), exp_fc);
    tick();
    chk({tag, "_e2"}, int'(error), 1);
    tick();
    chk({tag, "_e3"}, int'(error), 0);
  endtask

  task automatic do_reset(input string tag);
    #2 resetn = 1'b0;
    #1 outs_idle(tag);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    int cnt;
    checks   = 0;
    errors   = 0;
    resetn   = 1'b0;
    in_valid = 1'b0;
    in_bit   = 1'b0;
    prog_en  = 1'b0;
    new_code = '0;
    tick();
    outs_idle("rst");
    resetn = 1'b1;
    tick();
    outs_idle("rst_rel");

    // 1: reset code unlocks
    send_code(7'b1011000, "t1");
    chk("t1_fc", int'(fail_count), 0);

    // 2: zeros keep it open, a one relocks, idx restarts
    send_bit(1'b0); chk("t2_z0", int'(unlock), 1);
    send_bit(1'b0); chk("t2_z1", int'(unlock), 1);
    send_bit(1'b1); chk("t2_rl", int'(unlock), 0);
    send_code(7'b1011000, "t2");
    send_bit(1'b1); chk("t2_rl2", int'(unlock), 0);

    // 3: wrong at idx 1, bits during ERROR ignored
    send_bit(1'b1); chk("t3_b0", int'(error), 0);
    send_bit(1'b1); chk("t3_e1", int'(error), 1);
    chk("t3_fc", int'(fail_count), 1);
    send_bit(1'b1); chk("t3_e2", int'(error), 1);
    send_bit(1'b0); chk("t3_e3", int'(error), 0);
    chk("t3_fc2", int'(fail_count), 1);
    send_code(7'b1011000, "t3");
    chk("t3_fc0", int'(fail_count), 0);
    send_bit(1'b1);

    // 4: three failures -> 16-cycle lockout, correct code inside ignored
    wrong_attempt(1, "t4a");
    wrong_attempt(2, "t4b");
    wrong_attempt(3, "t4c");
    chk("t4_lck", int'(lockout), 1);
    chk("t4_fc3", int'(fail_count), 3);
    cnt = 1;
    for (int i = 6; i >= 0; i--) begin
      send_bit(logic'((7'b1011000 >> i) & 7'd1));
      if (lockout) cnt++;
      chk("t4_nounl", int'(unlock), 0);
    end
    for (int i = 0; i < 30; i++) begin
      tick();
      if (lockout) cnt++;
      else break;
    end
    chk("t4_len", cnt, 16);
    chk("t4_fc0", int'(fail_count), 0);
    chk("t4_unl0", int'(unlock), 0);
    send_code(7'b1011000, "t4");

    // 5: reprogram together with a relock bit in the same cycle
    prog_en  = 1'b1;
    new_code = 7'b0000001;
    in_valid = 1'b1;
    in_bit   = 1'b1;
    tick();
    prog_en  = 1'b0;
    in_valid = 1'b0;
    in_bit   = 1'b0;
    chk("t5_rl", int'(unlock), 0);
    send_bit(1'b1);
    chk("t5_old", int'(error), 1);
    tick(); tick();
    chk("t5_fc", int'(fail_count), 1);
    send_code(7'b0000001, "t5n");
    // prog_en outside UNLOCKED must not touch the code
    send_bit(1'b1);
    prog_en  = 1'b1;
    new_code = 7'b1111111;
    tick();
    prog_en  = 1'b0;
    send_code(7'b0000001, "t5k");
    do_reset("t5rst");
    send_code(7'b1011000, "t5r");
    send_bit(1'b1);

    // 6: asynchronous reset mid-lockout and mid-attempt
    wrong_attempt(1, "t6a");
    wrong_attempt(2, "t6b");
    wrong_attempt(3, "t6c");
    tick(); tick();
    chk("t6_lck", int'(lockout), 1);
    do_reset("t6l");
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    chk("t6_mid", int'(error), 0);
    do_reset("t6i");
    send_code(7'b1011000, "t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
